// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and constants for the PCIe TX requester arbiter.
package pcie_tx_arb_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ACK    = 4'b0010,
    S_BUSY   = 4'b0100,
    S_SETTLE = 4'b1000
  } state_t;

  localparam int unsigned CPLD  = 0;
  localparam int unsigned MRD   = 1;
  localparam int unsigned MWR   = 2;
  localparam int unsigned N_REQ = 3;

  // Settle counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pcie_tx_arb_rr_pick3.sv
// Combinational 3-way round-robin picker with optional CPLD priority override.
module rr_pick3
  import pcie_tx_arb_pkg::*;
(
  input  logic [N_REQ-1:0] elig,
  input  logic [N_REQ-1:0] last,
  input  logic             prio_en,
  output logic [N_REQ-1:0] win
);

  // Search starts at the index after the last-served one, wrapping.
  always_comb begin
    win = '0;
    if (prio_en && elig[CPLD]) begin
      win = 3'b001;
    end else begin
      case (last)
        3'b001:  win = elig[MRD]  ? 3'b010 : elig[MWR]  ? 3'b100 : elig[CPLD] ? 3'b001 : 3'b000;
        3'b010:  win = elig[MWR]  ? 3'b100 : elig[CPLD] ? 3'b001 : elig[MRD]  ? 3'b010 : 3'b000;
        default: win = elig[CPLD] ? 3'b001 : elig[MRD]  ? 3'b010 : elig[MWR]  ? 3'b100 : 3'b000;
      endcase
    end
  end

endmodule

// File: rtl/pcie_tx_arb.sv
// Arbitrates CPLD / MRd / MWr requesters onto the TX TLP mux, gated by FC grants,
// with a settle window after each TLP so the credit snapshot can refresh.
module pcie_tx_arb
  import pcie_tx_arb_pkg::*;
#(
  parameter int unsigned P_GNT_SETTLE    = 4,
  parameter bit          P_CPLD_PRIORITY = 1'b1
) (
  input  logic       pcie_user_clk,
  input  logic       pcie_user_rst,
  input  logic       tx_cpld_gnt,
  input  logic       tx_mrd_gnt,
  input  logic       tx_mwr_gnt,
  input  logic       cpld_req,
  output logic       cpld_ack,
  input  logic       cpld_done,
  input  logic       mrd_req,
  output logic       mrd_ack,
  input  logic       mrd_done,
  input  logic       mwr_req,
  output logic       mwr_ack,
  input  logic       mwr_done,
  output logic [2:0] tx_sel,
  output logic       tx_arb_busy
);

  localparam int unsigned        CNT_W       = cnt_width(P_GNT_SETTLE);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(P_GNT_SETTLE);

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   r_sel, sel_nxt;
  logic [N_REQ-1:0]   last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   ack_q, ack_nxt;
  logic [N_REQ-1:0]   tx_sel_nxt;
  logic               busy_nxt;
  logic [N_REQ-1:0]   elig, done_v, win;
  logic               sel_done;

  assign elig     = {mwr_req & tx_mwr_gnt, mrd_req & tx_mrd_gnt, cpld_req & tx_cpld_gnt};
  assign done_v   = {mwr_done, mrd_done, cpld_done};
  assign sel_done = |(done_v & r_sel);

  rr_pick3 u_pick (
    .elig    (elig),
    .last    (last),
    .prio_en (P_CPLD_PRIORITY),
    .win     (win)
  );

  // Next state plus next registered outputs, decoded from next state and selection.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = r_sel;
    last_nxt   = last;
    cnt_nxt    = cnt;
    ack_nxt    = '0;
    tx_sel_nxt = '0;
    busy_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|elig) begin
          state_nxt = S_ACK;
          sel_nxt   = win;
          last_nxt  = win;
        end
      end
      S_ACK, S_BUSY: begin
        if (sel_done) begin
          if (P_GNT_SETTLE == 0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end
        end else begin
          state_nxt = S_BUSY;
        end
      end
      S_SETTLE: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_ACK) begin
      ack_nxt = sel_nxt;
    end
    if (state_nxt == S_ACK || state_nxt == S_BUSY) begin
      tx_sel_nxt = sel_nxt;
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      state       <= S_IDLE;
      r_sel       <= '0;
      last        <= 3'b100;
      cnt         <= '0;
      ack_q       <= '0;
      tx_sel      <= '0;
      tx_arb_busy <= 1'b0;
    end else begin
      state       <= state_nxt;
      r_sel       <= sel_nxt;
      last        <= last_nxt;
      cnt         <= cnt_nxt;
      ack_q       <= ack_nxt;
      tx_sel      <= tx_sel_nxt;
      tx_arb_busy <= busy_nxt;
    end
  end

  assign cpld_ack = ack_q[CPLD];
  assign mrd_ack  = ack_q[MRD];
  assign mwr_ack  = ack_q[MWR];

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Randomized bench for pcie_tx_arb: three parameterisations driven in parallel,
// each checked every cycle against a transaction-level ownership model.
module tb_pcie_tx_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] req_v  [3];
  logic [2:0] gnt_v  [3];
  logic [2:0] done_v [3];
  wire  [2:0] ack_v  [3];
  wire  [2:0] sel_v  [3];
  wire        busy_v [3];

  // Instance 0: settle 4, CPLD priority; 1: settle 4, round-robin; 2: settle 0, round-robin.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pcie_tx_arb #(
      .P_GNT_SETTLE    ((g == 2) ? 0 : 4),
      .P_CPLD_PRIORITY ((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .pcie_user_clk (clk),
      .pcie_user_rst (rst),
      .tx_cpld_gnt   (gnt_v[g][0]),
      .tx_mrd_gnt    (gnt_v[g][1]),
      .tx_mwr_gnt    (gnt_v[g][2]),
      .cpld_req      (req_v[g][0]),
      .cpld_ack      (ack_v[g][0]),
      .cpld_done     (done_v[g][0]),
      .mrd_req       (req_v[g][1]),
      .mrd_ack       (ack_v[g][1]),
      .mrd_done      (done_v[g][1]),
      .mwr_req       (req_v[g][2]),
      .mwr_ack       (ack_v[g][2]),
      .mwr_done      (done_v[g][2]),
      .tx_sel        (sel_v[g]),
      .tx_arb_busy   (busy_v[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the TX path (-1 = nobody), whether this is its first cycle,
  // how many settle cycles remain, and which requester was served last.
  int m_owner [3];
  bit m_first [3];
  int m_wait  [3];
  int m_last  [3];

  function automatic int settle_of(input int i);
    return (i == 2) ? 0 : 4;
  endfunction

  function automatic bit prio_of(input int i);
    return (i == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_first[i] = 1'b0;
      m_wait[i]  = 0;
      m_last[i]  = 2;
    end
  endtask

  task automatic model_step();
    logic [2:0] elig;
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (m_owner[i] >= 0) begin
        m_first[i] = 1'b0;
        if (done_v[i][m_owner[i]]) begin
          m_owner[i] = -1;
          m_wait[i]  = settle_of(i);
        end
      end else if (m_wait[i] > 0) begin
        m_wait[i]--;
      end else begin
        elig = req_v[i] & gnt_v[i];
        w = -1;
        if (prio_of(i) && elig[0]) w = 0;
        else begin
          for (int k = 1; k <= 3; k++) begin
            if (w < 0 && elig[(m_last[i] + k) % 3]) w = (m_last[i] + k) % 3;
          end
        end
        if (w >= 0) begin
          m_owner[i] = w;
          m_first[i] = 1'b1;
          m_last[i]  = w;
        end
      end
    end
  endtask

  task automatic compare();
    logic [2:0] e_ack, e_sel;
    logic       e_busy;
    for (int i = 0; i < 3; i++) begin
      e_sel  = (m_owner[i] >= 0) ? 3'(1 << m_owner[i]) : 3'b000;
      e_ack  = m_first[i] ? e_sel : 3'b000;
      e_busy = (m_owner[i] >= 0) || (m_wait[i] > 0);
      chk($sformatf("ack%0d", i),  {5'b0, ack_v[i]}, {5'b0, e_ack});
      chk($sformatf("sel%0d", i),  {5'b0, sel_v[i]}, {5'b0, e_sel});
      chk($sformatf("busy%0d", i), {7'b0, busy_v[i]}, {7'b0, e_busy});
    end
  endtask

  // Requester behaviour: hold req until ack, finish the TLP 0..4 cycles later.
  int own_cnt [3][3];

  task automatic drive_reqs(input bit keep, input bit rnd_gnt, input bit rnd_rst);
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 3; r++) begin
        done_v[i][r] = 1'b0;
        if (ack_v[i][r] === 1'b1) begin
          own_cnt[i][r] = $urandom_range(0, 4);
          if (!keep && $urandom_range(0, 1) == 0) req_v[i][r] = 1'b0;
        end
        if (own_cnt[i][r] >= 0) begin
          if (own_cnt[i][r] == 0) begin
            done_v[i][r]  = 1'b1;
            own_cnt[i][r] = -1;
          end else begin
            own_cnt[i][r]--;
          end
        end else begin
          if (keep || (!req_v[i][r] && $urandom_range(0, 2) == 0)) req_v[i][r] = 1'b1;
          if (!keep && $urandom_range(0, 19) == 0) done_v[i][r] = 1'b1;
        end
        if (rnd_gnt && $urandom_range(0, 5) == 0) gnt_v[i][r] = ~gnt_v[i][r];
      end
    end
    rst = rnd_rst && ($urandom_range(0, 249) == 0);
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int r = 0; r < 3; r++) own_cnt[i][r] = -1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_v[i]  = 3'b000;
      gnt_v[i]  = 3'b000;
      done_v[i] = 3'b000;
      for (int r = 0; r < 3; r++) own_cnt[i][r] = -1;
    end
    model_reset();

    repeat (2) cycle();

    // MWr requesting without credits: must never be acked.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 3'b100;
      gnt_v[i] = 3'b011;
    end
    repeat (50) cycle();

    // Credits arrive; then all requesters held high for priority / RR ordering.
    for (int i = 0; i < 3; i++) gnt_v[i] = 3'b111;
    for (int c = 0; c < 200; c++) begin
      cycle();
      drive_reqs(1'b1, 1'b0, 1'b0);
    end

    // Fully random requests, spurious dones, grant toggles and resets.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      drive_reqs(1'b0, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
